// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the multi-channel PWM generator.
//   - Default parameter widths (channel count, counter width, prescaler width).
//   - Channel mode encodings used by pwm_channel.
// -----------------------------------------------------------------------------
package pwm_pkg;

  // Default parameter values
  localparam int unsigned N_CH_DEF  = 4;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned PSC_W_DEF = 8;

  // Channel mode encodings (2 bits per channel in the functions bus)
  localparam logic [1:0] MODE_LEFT      = 2'b00;  // high while cnt <  c1
  localparam logic [1:0] MODE_RIGHT     = 2'b01;  // high while cnt >= c1
  localparam logic [1:0] MODE_UNALIGNED = 2'b10;  // high while c1 <= cnt < c2
  localparam logic [1:0] MODE_RSVD      = 2'b11;  // output held low

endpackage : pwm_pkg

// File: rtl/pwm_channel.sv
// -----------------------------------------------------------------------------
// pwm_channel
// One PWM output channel. Holds the channel's active mode and compare pair
// and the registered output. The output is computed from the counter value
// being written at the same edge, so it lines up with count_val.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en_i        global enable; output forced low when 0
//   load_i      transfer the shadow values into the active registers
//   cnt_next_i  counter value being written at this edge
//   mode_sh_i   shadow mode
//   c1_sh_i     shadow compare1
//   c2_sh_i     shadow compare2
//   pwm_o       registered PWM output
// -----------------------------------------------------------------------------
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] cnt_next_i,
  input  logic [1:0]       mode_sh_i,
  input  logic [CNT_W-1:0] c1_sh_i,
  input  logic [CNT_W-1:0] c2_sh_i,
  output logic             pwm_o
);

  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] c1_q, c1_d;
  logic [CNT_W-1:0] c2_q, c2_d;
  logic             pwm_q, pwm_d;
  logic             level;

  // The values written into the active registers at this edge are also the
  // ones used for this edge's output, so a reload takes effect on the very
  // output that coincides with the counter returning to 0.
  always_comb begin
    mode_d = load_i ? mode_sh_i : mode_q;
    c1_d   = load_i ? c1_sh_i   : c1_q;
    c2_d   = load_i ? c2_sh_i   : c2_q;
  end

  always_comb begin
    level = 1'b0;
    case (mode_d)
      MODE_LEFT:      level = (cnt_next_i < c1_d);
      MODE_RIGHT:     level = (cnt_next_i >= c1_d);
      MODE_UNALIGNED: level = (c1_d <= cnt_next_i) && (cnt_next_i < c2_d);
      default:        level = 1'b0;
    endcase
    pwm_d = en_i & level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_LEFT;
      c1_q   <= '0;
      c2_q   <= '0;
      pwm_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      c1_q   <= c1_d;
      c2_q   <= c2_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule : pwm_channel

// File: rtl/pwm_multi_gen.sv
// -----------------------------------------------------------------------------
// pwm_multi_gen
// Multi-channel PWM generator with its own prescaled up-counter. All channels
// share one period; each channel has its own mode and compare pair. Period,
// prescale, modes and compares are double-buffered: shadow inputs move to the
// active registers only at counter overflow after a load request, or
// continuously while the generator is disabled.
//
// Optional feature macro: PWM_OVF_IRQ_EN
//   Adds irq_clr (in) and ovf_irq (out), a sticky overflow flag. Set wins
//   over a simultaneous clear.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   pwm_en       global enable
//   period       shadow period, counter runs 0..period
//   prescale     shadow prescale, one counter tick every prescale+1 clocks
//   functions    shadow modes, bits [2i+1:2i] for channel i
//   compare1     shadow compare1, slice i for channel i
//   compare2     shadow compare2, slice i for channel i
//   load_req     request transfer of shadow values at the next overflow
//   count_val    current counter value (registered)
//   pwm_out      PWM outputs (registered)
//   reload_done  one-cycle pulse when the new active values first apply
// -----------------------------------------------------------------------------
module pwm_multi_gen
  import pwm_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned PSC_W = PSC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pwm_en,
  input  logic [CNT_W-1:0]      period,
  input  logic [PSC_W-1:0]      prescale,
  input  logic [2*N_CH-1:0]     functions,
  input  logic [N_CH*CNT_W-1:0] compare1,
  input  logic [N_CH*CNT_W-1:0] compare2,
  input  logic                  load_req,
`ifdef PWM_OVF_IRQ_EN
  input  logic                  irq_clr,
  output logic                  ovf_irq,
`endif
  output logic [CNT_W-1:0]      count_val,
  output logic [N_CH-1:0]       pwm_out,
  output logic                  reload_done
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             en_q, en_d;              // pwm_en seen at the previous edge
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_act_q, period_act_d;
  logic [PSC_W-1:0] prescale_act_q, prescale_act_d;
  logic             load_pending_q, load_pending_d;
  logic             reload_done_q, reload_done_d;

  logic             tick;
  logic             ovf;
  logic             reload;
  logic             load_act;

  // ---------------------------------------------------------------------------
  // Tick / overflow / reload decode
  // ---------------------------------------------------------------------------
  // The first enabled edge is a start edge: the counter is written as 0 and
  // no tick is taken, so count 0 lasts a full tick like every other value.
  // The >= comparisons keep the counter safe if an active value ever sits
  // below the running count.
  always_comb begin
    tick     = pwm_en & en_q & (psc_q >= prescale_act_q);
    ovf      = tick & (cnt_q >= period_act_q);
    reload   = ovf & (load_pending_q | load_req);
    // While disabled the active registers simply track the shadows.
    load_act = ~pwm_en | reload;
  end

  // ---------------------------------------------------------------------------
  // Prescaler and counter next state
  // ---------------------------------------------------------------------------
  always_comb begin
    en_d  = pwm_en;
    psc_d = '0;
    cnt_d = '0;
    if (pwm_en && en_q) begin
      if (tick) begin
        psc_d = '0;
        cnt_d = ovf ? '0 : cnt_q + CNT_W'(1);
      end else begin
        psc_d = psc_q + PSC_W'(1);
        cnt_d = cnt_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reload bookkeeping and shared active registers
  // ---------------------------------------------------------------------------
  always_comb begin
    if (!pwm_en || reload) begin
      load_pending_d = 1'b0;
    end else if (load_req) begin
      load_pending_d = 1'b1;
    end else begin
      load_pending_d = load_pending_q;
    end

    period_act_d   = load_act ? period   : period_act_q;
    prescale_act_d = load_act ? prescale : prescale_act_q;
    reload_done_d  = reload;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q           <= 1'b0;
      psc_q          <= '0;
      cnt_q          <= '0;
      period_act_q   <= '0;
      prescale_act_q <= '0;
      load_pending_q <= 1'b0;
      reload_done_q  <= 1'b0;
    end else begin
      en_q           <= en_d;
      psc_q          <= psc_d;
      cnt_q          <= cnt_d;
      period_act_q   <= period_act_d;
      prescale_act_q <= prescale_act_d;
      load_pending_q <= load_pending_d;
      reload_done_q  <= reload_done_d;
    end
  end

  assign count_val   = cnt_q;
  assign reload_done = reload_done_q;

  // ---------------------------------------------------------------------------
  // Channels
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      pwm_channel #(
        .CNT_W (CNT_W)
      ) u_ch (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (pwm_en),
        .load_i     (load_act),
        .cnt_next_i (cnt_d),
        .mode_sh_i  (functions[2*gi +: 2]),
        .c1_sh_i    (compare1[gi*CNT_W +: CNT_W]),
        .c2_sh_i    (compare2[gi*CNT_W +: CNT_W]),
        .pwm_o      (pwm_out[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Optional sticky overflow flag
  // ---------------------------------------------------------------------------
`ifdef PWM_OVF_IRQ_EN
  logic ovf_irq_q, ovf_irq_d;

  always_comb begin
    if (ovf) begin
      ovf_irq_d = 1'b1;
    end else if (irq_clr) begin
      ovf_irq_d = 1'b0;
    end else begin
      ovf_irq_d = ovf_irq_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_irq_q <= 1'b0;
    end else begin
      ovf_irq_q <= ovf_irq_d;
    end
  end

  assign ovf_irq = ovf_irq_q;
`endif

endmodule : pwm_multi_gen
